// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle MIPS-subset datapath: sequences fetch,
// decode, memory, ALU, branch and jump steps and traps on unsupported encodings.
module multicycle_control_unit #(
  parameter int MEM_LATENCY = 0,
  parameter int ALU_CTRL_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic                  imm_zext,
  output logic                  instr_done,
  output logic                  illegal,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_src,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP, TRAP
  } state_e;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;
  localparam logic [5:0] ALU_XOR = 6'h26;
  localparam logic [5:0] ALU_NOR = 6'h27;
  localparam logic [5:0] ALU_SLT = 6'h2A;

  function automatic logic funct_valid(input logic [5:0] f);
    return f inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT};
  endfunction

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       start_q, start_d;
  logic [5:0] alu_op_q, alu_op_d;
  logic       zext_q, zext_d;
  logic       mem_last;
  logic [5:0] alu_op;

  assign mem_last = (wait_q == LAST_WAIT);

  // ALU operation and zero-extend flag are captured at decode so that the
  // execute and write-back outputs never depend combinationally on the IR.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    wait_d   = '0;
    start_d  = 1'b1;
    alu_op_d = alu_op_q;
    zext_d   = zext_q;
    unique case (state_q)
      IDLE:   if (start_q) state_d = FETCH;
      FETCH:  if (mem_last) state_d = DECODE;
              else wait_d = wait_q + 4'd1;
      DECODE: begin
        unique case (opcode)
          OP_RTYPE: begin state_d = EXEC;  alu_op_d = funct;   zext_d = 1'b0; end
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_ADDI:  begin state_d = IEXEC; alu_op_d = ALU_ADD; zext_d = 1'b0; end
          OP_ANDI:  begin state_d = IEXEC; alu_op_d = ALU_AND; zext_d = 1'b1; end
          OP_ORI:   begin state_d = IEXEC; alu_op_d = ALU_OR;  zext_d = 1'b1; end
          OP_BEQ:   state_d = BRANCH;
          OP_J:     state_d = JUMP;
          default:  state_d = TRAP;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_last) state_d = MEMWB;
              else wait_d = wait_q + 4'd1;
      MEMWR:  if (mem_last) state_d = FETCH;
              else wait_d = wait_q + 4'd1;
      EXEC:   state_d = funct_valid(funct) ? ALUWB : TRAP;
      IEXEC:  state_d = IWB;
      MEMWB, ALUWB, IWB, BRANCH, JUMP: state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // start_q delays the first fetch by one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      start_q  <= 1'b0;
      alu_op_q <= '0;
      zext_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      start_q  <= start_d;
      alu_op_q <= alu_op_d;
      zext_q   <= zext_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    imm_zext      = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = '0;
    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_last;
        pc_write  = mem_last;
      end
      DECODE: begin alu_src_b = 2'b11; alu_op = ALU_ADD; end
      MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = ALU_ADD; end
      MEMRD:  begin iord = 1'b1; mem_read = 1'b1; end
      MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; instr_done = 1'b1; end
      MEMWR:  begin iord = 1'b1; mem_write = 1'b1; instr_done = mem_last; end
      EXEC:   begin alu_src_a = 1'b1; alu_op = alu_op_q; end
      ALUWB:  begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = alu_op_q;
        imm_zext  = zext_q;
      end
      IWB:    begin reg_write = 1'b1; imm_zext = zext_q; instr_done = 1'b1; end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP:   begin pc_write = 1'b1; pc_src = 2'b10; instr_done = 1'b1; end
      TRAP:   illegal = 1'b1;
      default: ;
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(alu_op);
  assign state    = state_q;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 0, meaning extra wait cycles per memory access (0..15).
REQ-002 SHALL have parameter ALU_CTRL_W, default 6, meaning alu_ctrl width (>=6; upper bits zero).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port opcode, input, 6, instruction[31:26], taken from the datapath IR.
REQ-006 SHALL have port funct, input, 6, instruction[5:0].
REQ-007 SHALL have port alu_ctrl, output, ALU_CTRL_W, ALU operation: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt.
REQ-008 SHALL have 1-bit outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, imm_zext, instr_done, illegal.
REQ-009 SHALL have outputs alu_src_b[1:0] (00 B, 01 const 4, 10 sext imm, 11 sext imm<<2) and pc_src[1:0] (00 ALU, 01 ALUOut, 10 jump target).
REQ-010 SHALL have output state[3:0], the current FSM state encoding, for debug.

Function
REQ-011 SHALL be a Moore FSM; every output is decoded from state and the wait counter only, with no combinational path from opcode/funct.
REQ-012 SHALL use states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP, TRAP.
REQ-013 SHALL go IDLE->FETCH unconditionally; every output is 0 in IDLE.
REQ-014 SHALL, in FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_ctrl=0x20, pc_src=00; ir_write=1 and pc_write=1 only on the last FETCH cycle.
REQ-015 SHALL hold FETCH, MEMRD and MEMWR for exactly MEM_LATENCY+1 cycles, using a wait counter cleared on entry to each of those states.
REQ-016 SHALL, in DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=0x20; next state from opcode.
REQ-017 DECODE branching SHALL be: 0x00 EXEC, 0x23/0x2B MEMADR, 0x08/0x0C/0x0D IEXEC, 0x04 BRANCH, 0x02 JUMP, others TRAP.
REQ-018 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=0x20, then go to MEMRD on 0x23 or MEMWR on 0x2B.
REQ-019 MEMRD SHALL drive iord=1, mem_read=1, then go to MEMWB; MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-020 MEMWR SHALL drive iord=1 and mem_write=1 for every cycle it is held.
REQ-021 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=funct, valid for funct 0x20,22,24,25,26,27,2A; any other funct SHALL go to TRAP instead of ALUWB.
REQ-022 ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-023 IEXEC SHALL drive alu_src_a=1, alu_src_b=10, and alu_ctrl 0x20/0x24/0x25 for addi/andi/ori, with imm_zext=1 for andi/ori.
REQ-024 IWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, holding imm_zext as in IEXEC.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=0x22, pc_write_cond=1, pc_src=01.
REQ-026 JUMP SHALL drive pc_write=1, pc_src=10.
REQ-027 MEMWB, MEMWR last cycle, ALUWB, IWB, BRANCH and JUMP SHALL pulse instr_done=1 and go to FETCH.
REQ-028 TRAP SHALL be absorbing; illegal=1 and all other outputs 0 until reset.
REQ-029 opcode/funct SHALL be sampled only in DECODE/MEMADR/EXEC/IEXEC/IWB; the IR holds them stable from the FETCH ir_write until the next fetch.
REQ-030 Default outputs SHALL be 0 in any state not listed as driving them.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, wait counter=0, and every output to 0, including in mid-instruction or TRAP.
REQ-032 After rst_n deasserts, the first FETCH cycle SHALL follow on the second rising edge of clk.

Verification
REQ-033 MEM_LATENCY=0, opcode 0x00, funct 0x22 -> FETCH,DECODE,EXEC(alu_ctrl=0x22),ALUWB(reg_write=1,reg_dst=1); instr_done once per 4 cycles.
REQ-034 MEM_LATENCY=2, lw 0x23 -> FETCH held 3 cycles with ir_write only in the 3rd, MEMRD held 3 cycles, MEMWB mem_to_reg=1; 9 cycles total.
REQ-035 sw 0x2B, MEM_LATENCY=0 -> mem_write=1 for exactly one cycle, reg_write never 1, 4 cycles total.
REQ-036 beq 0x04 -> BRANCH with alu_ctrl=0x22, pc_write_cond=1, pc_src=01; j 0x02 -> pc_write=1, pc_src=10; 3 cycles each.
REQ-037 opcode 0x3F, or R-type funct 0x08 -> TRAP, illegal=1 held 100 cycles; rst_n low -> all outputs 0 immediately.
REQ-038 rst_n asserted during MEMRD of lw -> mem_read drops at once, no MEMWB; after release IDLE then FETCH.
